// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation encoding driven by the controller.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MFHI  = 2'b10,
    OP_MFLO  = 2'b11
  } op_t;

  // Sequencer states: idle, iterating a multiply, iterating a divide.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_t;

  // Register 0 is hardwired to zero; writes to it are suppressed.
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a {hi,lo}
// accumulator. Purely combinational; the top level registers the result.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;     // acc_hi + multiplicand with carry out
  logic [WIDTH:0]   rem_sh;  // partial remainder shifted left by one bit
  logic [WIDTH-1:0] diff;    // rem_sh - divisor, valid only when rem_sh >= divisor
  logic             ge;      // trial subtraction succeeds

  // Multiply: add multiplicand when the multiplier LSB is set, then shift
  // the whole accumulator right. Divide: shift left, trial subtract, and
  // shift the quotient bit into the low word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    sum    = {1'b0, acc_hi} + {1'b0, operand};
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, operand});
    // Remainder stays below the divisor (or below 2^WIDTH when dividing by
    // zero), so the low WIDTH bits of the difference are exact.
    diff   = rem_sh[WIDTH-1:0] - operand;
    if (!div_mode) begin
      if (acc_lo[0]) begin
        {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
      end else begin
        {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
      end
    end else begin
      if (ge) begin
        nxt_hi = diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU with HI/LO registers and MFHI/MFLO
// writeback toward the register file. One operation in flight at a time.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [4:0]       dest,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             wb_we,
  output logic [4:0]       wb_wa,
  output logic [WIDTH-1:0] wb_wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t           state, state_nxt;
  logic             load_mul, load_div, accept_mf, last_step;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign busy  = (state != S_IDLE);
  assign stall = start & busy;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == S_DIV),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (opnd),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    load_mul  = 1'b0;
    load_div  = 1'b0;
    accept_mf = 1'b0;
    last_step = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op_t'(op))
            OP_MULTU: begin load_mul = 1'b1; state_nxt = S_MUL; end
            OP_DIVU:  begin load_div = 1'b1; state_nxt = S_DIV; end
            default:  accept_mf = 1'b1;
          endcase
        end
      end
      default: begin
        if (cnt == LAST_CNT) begin
          last_step = 1'b1;
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Operand latch, iteration accumulator and HI/LO commit. HI/LO change
  // only on the final step, so partial results never become visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= last_step;
      if (load_mul || load_div) begin
        cnt    <= '0;
        acc_hi <= '0;
        // Multiply keeps the multiplier in the low word and adds the
        // multiplicand; divide shifts the dividend out of the low word.
        acc_lo <= load_mul ? srcb : srca;
        opnd   <= load_mul ? srca : srcb;
      end else if (busy) begin
        cnt    <= cnt + CNT_W'(1);
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (last_step) begin
          hi <= step_hi;
          lo <= step_lo;
        end
      end
    end
  end

  // MFHI/MFLO writeback: one-cycle write pulse, suppressed for register 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_we <= 1'b0;
      wb_wa <= '0;
      wb_wd <= '0;
    end else begin
      wb_we <= accept_mf && (dest != ZERO_REG);
      if (accept_mf) begin
        wb_wa <= dest;
        wb_wd <= (op_t'(op) == OP_MFHI) ? hi : lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0, srcb = '0;
  logic [4:0]  dest = '0;
  logic        busy, stall, done, wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd, hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .dest(dest),
    .busy(busy), .stall(stall), .done(done),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation: inputs set, accepted at the next edge, start dropped.
  task automatic issue(input op_t o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    start = 1'b1; op = o; srca = a; srcb = b; dest = d;
    step();
    start = 1'b0;
  endtask

  // Count sampled busy cycles (bounded) and note whether hi/lo moved while busy.
  task automatic wait_idle(input logic [31:0] old_hi, input logic [31:0] old_lo,
                           output int n, output logic held);
    n = 0;
    held = 1'b1;
    while (busy && n < 200) begin
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      n++;
      step();
    end
  endtask

  int   n;
  logic held;
  logic saw_done;
  logic saw_we;

  initial begin
    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    step();
    check("rel_done", {31'd0, done}, 32'd0);

    // 1: MULTU FFFFFFFF x FFFFFFFF
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check("mul1_busy0", {31'd0, busy}, 32'd1);
    wait_idle(32'd0, 32'd0, n, held);
    check("mul1_cycles", n, 32'd32);
    check("mul1_held", {31'd0, held}, 32'd1);
    check("mul1_done", {31'd0, done}, 32'd1);
    check("mul1_hi", hi, 32'hFFFF_FFFE);
    check("mul1_lo", lo, 32'h0000_0001);
    step();
    check("mul1_done_pulse", {31'd0, done}, 32'd0);

    // 2: DIVU 100/7, then divide by zero
    issue(OP_DIVU, 32'd100, 32'd7, 5'd0);
    wait_idle(32'hFFFF_FFFE, 32'h1, n, held);
    check("div1_cycles", n, 32'd32);
    check("div1_held", {31'd0, held}, 32'd1);
    check("div1_lo", lo, 32'd14);
    check("div1_hi", hi, 32'd2);
    issue(OP_DIVU, 32'h1234_5678, 32'd0, 5'd0);
    wait_idle(32'd2, 32'd14, n, held);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234_5678);

    // 3: MULTU 2^16 x 2^16, MFHI in the done cycle, MFLO back-to-back
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 5'd0);
    wait_idle(32'h1234_5678, 32'hFFFF_FFFF, n, held);
    check("mul3_done", {31'd0, done}, 32'd1);
    start = 1'b1; op = OP_MFHI; dest = 5'd5;
    step();
    check("mfhi_we", {31'd0, wb_we}, 32'd1);
    check("mfhi_wa", {27'd0, wb_wa}, 32'd5);
    check("mfhi_wd", wb_wd, 32'h0000_0001);
    op = OP_MFLO; dest = 5'd6;
    step();
    start = 1'b0;
    check("mflo_we", {31'd0, wb_we}, 32'd1);
    check("mflo_wa", {27'd0, wb_wa}, 32'd6);
    check("mflo_wd", wb_wd, 32'h0000_0000);
    step();
    check("mflo_we_pulse", {31'd0, wb_we}, 32'd0);

    // 4: MFLO to register 0 never writes
    issue(OP_MFLO, 32'd0, 32'd0, 5'd0);
    saw_we = wb_we;
    check("mf0_wa", {27'd0, wb_wa}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      saw_we = saw_we | wb_we;
    end
    check("mf0_no_we", {31'd0, saw_we}, 32'd0);

    // 5: MULTU 3x4 with MFLO held against stall
    issue(OP_MULTU, 32'd3, 32'd4, 5'd0);
    for (int i = 0; i < 4; i++) step();
    start = 1'b1; op = OP_MFLO; dest = 5'd8;
    #1;
    check("st_stall", {31'd0, stall}, 32'd1);
    saw_we = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      saw_we = saw_we | wb_we;
      if (lo !== 32'd0) saw_we = 1'b1;
      n++;
      step();
    end
    check("st_no_we_lo_held", {31'd0, saw_we}, 32'd0);
    check("st_stall_clear", {31'd0, stall}, 32'd0);
    check("st_lo", lo, 32'd12);
    step();
    start = 1'b0;
    check("st_mf_we", {31'd0, wb_we}, 32'd1);
    check("st_mf_wa", {27'd0, wb_wa}, 32'd8);
    check("st_mf_wd", wb_wd, 32'd12);

    // 6: DIVU 1000/3 aborted by reset, then MULTU 2x3
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd0);
    for (int i = 0; i < 9; i++) step();
    check("ab_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_hi", hi, 32'd0);
    check("ab_lo", lo, 32'd0);
    check("ab_wb_we", {31'd0, wb_we}, 32'd0);
    step();
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      saw_done = saw_done | done | busy;
    end
    check("ab_no_done", {31'd0, saw_done}, 32'd0);
    issue(OP_MULTU, 32'd2, 32'd3, 5'd0);
    wait_idle(32'd0, 32'd0, n, held);
    check("ab_mul_cycles", n, 32'd32);
    check("ab_mul_lo", lo, 32'd6);
    check("ab_mul_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative unsigned multiply/divide unit with HI/LO result registers, for the single-cycle/multicycle MIPS datapath.
- Sits directly downstream of the three-port register file: srca/srcb come from rd1/rd2.
- Sits upstream of the register-file write port: wb_we/wb_wa/wb_wd drive we3/wa3/wd3 (muxed with the normal writeback path) for MFHI/MFLO.
- One operation in flight at a time; start/busy handshake toward the controller.

Parameters:
WIDTH, 32, operand and HI/LO width
ITER, WIDTH, iterations per MULTU/DIVU (one bit per cycle)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled on rising clk edge
op  in  2  00 MULTU, 01 DIVU, 10 MFHI, 11 MFLO
srca  in  WIDTH  multiplicand / dividend (rd1)
srcb  in  WIDTH  multiplier / divisor (rd2)
dest  in  5  destination register for MFHI/MFLO
busy  out  1  MULTU/DIVU iterating
stall  out  1  combinational: start & busy
done  out  1  one-cycle pulse when HI/LO commit
wb_we  out  1  register-file write enable (one-cycle pulse)
wb_wa  out  5  register-file write address
wb_wd  out  WIDTH  register-file write data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, wb_we=0, wb_wa=0, wb_wd=0, hi=0, lo=0; iteration counter=0. Reset mid-operation aborts; no done pulse follows.
- States: IDLE, MUL, DIV.
  - IDLE + start + op=MULTU -> MUL: latch srca/srcb, counter=0.
  - IDLE + start + op=DIVU -> DIV: latch srca/srcb, counter=0.
  - MUL/DIV with counter==ITER-1 -> IDLE: commit HI/LO, done=1 next cycle.
- Latency: start accepted at edge E0; busy=1 from E0 through E32 (exactly ITER cycles); hi/lo hold new values and done=1 in the cycle after E32.
- hi/lo hold their old values while busy; no partial results are visible.
- MULTU: unsigned WIDTH x WIDTH -> 2*WIDTH shift-add, one multiplier bit per cycle. {hi,lo} = full product. No overflow is possible.
- DIVU: restoring division, one quotient bit per cycle. lo = quotient, hi = remainder.
- Divide by zero is not trapped: lo = all ones, hi = dividend. This is the natural restoring result.
- MFHI/MFLO: accepted when start=1 and busy=0.
  - Next cycle: wb_we=1, wb_wa=dest, wb_wd=hi (MFHI) or lo (MFLO). Deasserted the following cycle.
  - MFHI/MFLO issued in the done cycle returns the newly committed value.
  - dest==0: wb_we stays 0 (register 0 is hardwired to zero); wb_wa/wb_wd still update.
- Start while busy (any op): ignored; stall=1. The controller holds start/op/operands until stall=0.
- The first edge after completion with start=1 is accepted normally.
- start in IDLE with MFHI/MFLO does not assert busy; back-to-back MF ops every cycle are allowed.
- wb_we and done are registered outputs; never asserted in the same cycle as reset release.

Decomposition:
- Package muldiv_pkg holds:
  - op_t enum: OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO.
  - state_t enum: S_IDLE, S_MUL, S_DIV.
  - Constant ZERO_REG=5'd0.
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: mode, partial hi/lo accumulator, latched operand.
  - Outputs: next accumulator.
  - Instantiated once, used by both MUL and DIV states.
- The top level owns the state machine, counter, HI/LO and the writeback registers.

Test Plan:
1. MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> busy high exactly 32 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses for one cycle.
2. DIVU srca=100, srcb=7 -> after 32 cycles lo=14, hi=2. Then DIVU srca=0x12345678, srcb=0 -> lo=0xFFFFFFFF, hi=0x12345678.
3. MULTU 0x00010000 x 0x00010000, then MFHI dest=5 in the done cycle -> one cycle later wb_we=1, wb_wa=5, wb_wd=0x00000001. MFLO dest=6 on the next cycle -> wb_wd=0.
4. MFLO dest=0 -> wb_we remains 0 for all cycles.
5. MULTU 3x4 started; MFLO dest=8 asserted at cycle 5 of busy -> stall=1, no wb_we, lo unchanged while busy. After done, held MFLO is accepted -> wb_wd=12.
6. DIVU 1000/3 started, reset_n pulled low at cycle 10 -> busy, hi, lo, wb_we drop to 0 immediately (asynchronously); no done after release; a new MULTU 2x3 completes with lo=6.
